// File: rtl/spi_master.sv
// SPI initiator for the 7-bit-address SPI register slave.
//
// Frame, MSB first: addr[6:0], write flag, DATA_REGISTER_LENGTH data bits.
// SCK idles low. Each bit is an H phase (sck=1) followed by an L phase (sck=0),
// and each phase lasts CLK_DIV clk cycles. The slave samples on the falling
// edge of SCK. MOSI changes in the middle of the L phase.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           request a transaction; accepted only while the block is idle
//   addr, is_write  register address and direction, latched on accept
//   wdata           write data, latched on accept (shifted out for reads too)
//   rdata           data captured from miso, updated together with done
//   busy            high from accept through the end of the CS idle gap
//   done            one-cycle pulse when cs rises at the end of a frame
//   sck, mosi, cs   SPI outputs (cs active low)
//   miso            SPI input, already synchronised to clk
module spi_master #(
  parameter int unsigned DATA_REGISTER_LENGTH = 64,
  parameter int unsigned CLK_DIV              = 4,
  parameter int unsigned CS_SETUP             = 2,
  parameter int unsigned CS_HOLD              = 2,
  parameter int unsigned CS_IDLE              = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [6:0]                      addr,
  input  logic                            is_write,
  input  logic [DATA_REGISTER_LENGTH-1:0] wdata,
  output logic [DATA_REGISTER_LENGTH-1:0] rdata,
  output logic                            busy,
  output logic                            done,
  output logic                            sck,
  output logic                            mosi,
  input  logic                            miso,
  output logic                            cs
);

  localparam int unsigned NBits  = 8 + DATA_REGISTER_LENGTH;
  localparam int unsigned BitW   = $clog2(NBits);
  localparam int unsigned MaxA   = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
  localparam int unsigned MaxB   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HighLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] MosiAdv   = CntW'(CLK_DIV - 1 + CLK_DIV / 2);
  localparam logic [CntW-1:0] BitEnd    = CntW'(2 * CLK_DIV - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] IdleLast  = CntW'(CS_IDLE - 1);
  localparam logic [BitW-1:0] LastBit   = BitW'(NBits - 1);
  localparam logic [BitW-1:0] FirstData = BitW'(8);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [BitW-1:0]                 bit_q, bit_d;
  logic [NBits-1:0]                tx_q, tx_d;
  logic [DATA_REGISTER_LENGTH-1:0] rx_q, rx_d;
  logic [DATA_REGISTER_LENGTH-1:0] rdata_q, rdata_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            sck_q, sck_d;
  logic                            mosi_q, mosi_d;
  logic                            cs_q, cs_d;
  logic                            can_accept;

  // The last cycle of the gap doubles as an idle cycle. This lets start held
  // high produce exactly CS_IDLE cycles of cs=1 between frames.
  assign can_accept = (state_q == StIdle) || ((state_q == StGap) && (cnt_q == IdleLast));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;

    unique case (state_q)
      StIdle: ;
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HighLast) begin
          // Falling edge of sck; the address and flag bits carry no read data.
          sck_d = 1'b0;
          if (bit_q >= FirstData) begin
            rx_d = {rx_q[DATA_REGISTER_LENGTH-2:0], miso};
          end
        end
        if (cnt_q == MosiAdv) begin
          mosi_d = tx_q[NBits-1];
          tx_d   = tx_q << 1;
        end
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (bit_q == LastBit) begin
            state_d = StHold;
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StGap;
          cnt_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == IdleLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start && can_accept) begin
      state_d = StSetup;
      cnt_d   = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
      cs_d    = 1'b0;
      mosi_d  = addr[6];
      // tx holds the bits still to be sent; bit 0 is already on mosi.
      tx_d    = {addr[5:0], is_write, wdata, 1'b0};
      rx_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;
  assign cs    = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master. Instance 0 uses the default parameters. Instance 1 uses
// DATA_REGISTER_LENGTH=32 and CLK_DIV=6. A slave model decodes each frame from
// the SCK/MOSI waveform and serves read data on MISO.
module tb_spi_master;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start, is_write, busy, done, sck, mosi, miso, cs;
  logic [6:0]  addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata0;
  logic [31:0] rdata1;

  spi_master u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start[0]),
    .addr     (addr[0]),
    .is_write (is_write[0]),
    .wdata    (wdata[0]),
    .rdata    (rdata0),
    .busy     (busy[0]),
    .done     (done[0]),
    .sck      (sck[0]),
    .mosi     (mosi[0]),
    .miso     (miso[0]),
    .cs       (cs[0])
  );

  spi_master #(
    .DATA_REGISTER_LENGTH (32),
    .CLK_DIV              (6)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start[1]),
    .addr     (addr[1]),
    .is_write (is_write[1]),
    .wdata    (wdata[1][31:0]),
    .rdata    (rdata1),
    .busy     (busy[1]),
    .done     (done[1]),
    .sck      (sck[1]),
    .mosi     (mosi[1]),
    .miso     (miso[1]),
    .cs       (cs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int nbits(input int i);
    return (i == 0) ? 72 : 40;
  endfunction

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  function automatic logic [63:0] mask_of(input int i);
    return (i == 0) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Busy length from the timing rules: setup + two phases per bit + hold + gap.
  function automatic int busy_len(input int i);
    return 2 + 2 * cdiv(i) * nbits(i) + 2 + 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model / monitor ----------------
  typedef struct {
    logic [6:0]  a;
    logic        w;
    logic [63:0] d;
    int          falls;
  } frm_t;

  frm_t        obs0[$];
  frm_t        obs1[$];
  int          cyc;
  logic [1:0]  cs_prev  = 2'b11;
  logic [1:0]  sck_prev = 2'b00;
  int          rises[2], falls[2], dones[2], blen_run[2], last_blen[2];
  int          viol[2], per[2], last_rise[2], rise_cyc[2], gap[2];
  logic [71:0] frame  [2];
  logic [63:0] last_rd[2];
  logic [63:0] rd_val [2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int   nb, dl, k;
    frm_t f;
    for (int i = 0; i < 2; i++) begin
      nb = nbits(i);
      dl = nb - 8;
      if (cs[i] === 1'b0 && cs_prev[i] === 1'b1) begin
        gap[i]   = cyc - rise_cyc[i];
        rises[i] = 0;
        falls[i] = 0;
        frame[i] = '0;
      end
      if (sck[i] === 1'b1 && sck_prev[i] === 1'b0) begin
        k = rises[i];
        miso[i] = (k >= 8) ? rd_val[i][dl-1-(k-8)] : 1'b0;
        if (k > 0) per[i] = cyc - last_rise[i];
        last_rise[i] = cyc;
        rises[i]++;
      end
      if (sck[i] === 1'b0 && sck_prev[i] === 1'b1) begin
        frame[i] = {frame[i][70:0], mosi[i]};
        falls[i]++;
      end
      if (cs[i] === 1'b1 && cs_prev[i] === 1'b0) begin
        rise_cyc[i] = cyc;
        if (rst_n) begin
          f.a     = frame[i][nb-1 -: 7];
          f.w     = frame[i][nb-8];
          f.d     = frame[i][63:0] & mask_of(i);
          f.falls = falls[i];
          if (i == 0) obs0.push_back(f);
          else        obs1.push_back(f);
        end
      end
      if (cs[i] === 1'b1 && sck[i] === 1'b1) viol[i]++;
      if (done[i] === 1'b1) begin
        dones[i]++;
        last_rd[i] = (i == 0) ? rdata0 : {32'h0, rdata1};
      end
      if (busy[i] === 1'b1) begin
        blen_run[i]++;
      end else begin
        if (blen_run[i] != 0) last_blen[i] = blen_run[i];
        blen_run[i] = 0;
      end
      cs_prev[i]  = cs[i];
      sck_prev[i] = sck[i];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int i);
    int t = 0;
    while (busy[i] !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (busy[i] !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: inst %0d still busy after %0d cycles", i, t);
    end
    @(posedge clk);
  endtask

  task automatic txn(input int i, input logic [6:0] a, input logic w, input logic [63:0] d,
                     input logic [63:0] rv);
    rd_val[i] = rv;
    @(negedge clk);
    addr[i] = a; is_write[i] = w; wdata[i] = d; start[i] = 1'b1;
    @(negedge clk);
    // Scramble inputs right after accept; the frame must not change.
    start[i] = 1'b0; addr[i] = ~a; is_write[i] = ~w; wdata[i] = ~d;
    wait_idle(i);
  endtask

  task automatic run_vec(input int i, input logic [6:0] a, input logic w, input logic [63:0] d,
                         input logic [63:0] rv, input logic [63:0] exp_rd, input int exp_busy,
                         input string tag);
    int   d0;
    int   n;
    frm_t f;
    obs0.delete();
    obs1.delete();
    d0 = dones[i];
    txn(i, a, w, d, rv);
    n = (i == 0) ? obs0.size() : obs1.size();
    chk({tag, "_frames"}, 64'(n), 64'd1);
    if (n > 0) begin
      f = (i == 0) ? obs0.pop_front() : obs1.pop_front();
      chk({tag, "_addr"},  64'(f.a), 64'(a));
      chk({tag, "_wflag"}, 64'(f.w), 64'(w));
      chk({tag, "_wdata"}, f.d, d & mask_of(i));
      chk({tag, "_falls"}, 64'(f.falls), 64'(nbits(i)));
    end
    chk({tag, "_dones"}, 64'(dones[i] - d0), 64'd1);
    chk({tag, "_rdata"}, last_rd[i], exp_rd);
    chk({tag, "_busy_len"}, 64'(last_blen[i]), 64'(exp_busy));
  endtask

  typedef struct {
    int          inst;
    logic [6:0]  a;
    logic        w;
    logic [63:0] d;
    logic [63:0] rv;
    logic [63:0] exp_rd;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   d0, t, n;
    frm_t f;
    vecs[0] = '{0, 7'h15, 1'b1, 64'hDEADBEEF_01234567, 64'h0, 64'h0, 584};
    vecs[1] = '{0, 7'h02, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 584};
    vecs[2] = '{0, 7'h7F, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 584};
    vecs[3] = '{0, 7'h00, 1'b0, 64'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 584};
    vecs[4] = '{1, 7'h55, 1'b1, 64'hCAFE_F00D, 64'h8000_0001, 64'h8000_0001, 488};
    vecs[5] = '{1, 7'h2A, 1'b0, 64'h1234_5678, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 488};

    rst_n = 1'b0; start = '0; is_write = '0; miso = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; rd_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs",    64'(cs),    64'h3);
    chk("rst_sck",   64'(sck),   64'h0);
    chk("rst_mosi",  64'(mosi),  64'h0);
    chk("rst_busy",  64'(busy),  64'h0);
    chk("rst_done",  64'(done),  64'h0);
    chk("rst_rdata", rdata0,     64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v].inst, vecs[v].a, vecs[v].w, vecs[v].d, vecs[v].rv, vecs[v].exp_rd,
              vecs[v].exp_busy, $sformatf("vec%0d", v));
    end
    chk("sck_period_div4", 64'(per[0]), 64'd8);
    chk("sck_period_div6", 64'(per[1]), 64'd12);

    // start pulsed during busy is ignored.
    obs0.delete();
    d0 = dones[0];
    rd_val[0] = 64'h1111_2222_3333_4444;
    @(negedge clk);
    addr[0] = 7'h33; is_write[0] = 1'b1; wdata[0] = 64'h0BAD_F00D_1234_5678; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (98) @(negedge clk);
    addr[0] = 7'h44; wdata[0] = 64'h0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    chk("ign_busy_after", 64'(busy[0]), 64'd0);
    chk("ign_frames", 64'(obs0.size()), 64'd1);
    chk("ign_dones", 64'(dones[0] - d0), 64'd1);
    chk("ign_busy_len", 64'(last_blen[0]), 64'd584);
    if (obs0.size() > 0) begin
      f = obs0.pop_front();
      chk("ign_addr", 64'(f.a), 64'h33);
      chk("ign_falls", 64'(f.falls), 64'd72);
    end

    // start held high: back-to-back frames, second one latches new inputs.
    obs0.delete();
    d0 = dones[0];
    rd_val[0] = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    addr[0] = 7'h11; is_write[0] = 1'b1; wdata[0] = 64'h1111_0000_1111_0000; start[0] = 1'b1;
    @(negedge clk);
    addr[0] = 7'h22; is_write[0] = 1'b0; wdata[0] = 64'h2222_0000_2222_0000;
    t = 0;
    while (dones[0] < d0 + 2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    start[0] = 1'b0;
    wait_idle(0);
    chk("b2b_dones", 64'(dones[0] - d0), 64'd2);
    chk("b2b_cs_gap", 64'(gap[0]), 64'd4);
    n = obs0.size();
    chk("b2b_frames", 64'(n), 64'd2);
    if (n == 2) begin
      f = obs0.pop_front();
      chk("b2b_f0_addr", 64'(f.a), 64'h11);
      chk("b2b_f0_w", 64'(f.w), 64'd1);
      chk("b2b_f0_data", f.d, 64'h1111_0000_1111_0000);
      f = obs0.pop_front();
      chk("b2b_f1_addr", 64'(f.a), 64'h22);
      chk("b2b_f1_w", 64'(f.w), 64'd0);
      chk("b2b_f1_data", f.d, 64'h2222_0000_2222_0000);
    end
    chk("b2b_rdata", last_rd[0], 64'hFEDC_BA98_7654_3210);

    // Asynchronous reset in mid-frame.
    obs0.delete();
    d0 = dones[0];
    @(negedge clk);
    addr[0] = 7'h5A; is_write[0] = 1'b1; wdata[0] = 64'h5555_AAAA_5555_AAAA; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (298) @(negedge clk);
    chk("mrst_busy_before", 64'(busy[0]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cs", 64'(cs[0]), 64'd1);
    chk("mrst_sck", 64'(sck[0]), 64'd0);
    chk("mrst_busy", 64'(busy[0]), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_no_done", 64'(dones[0] - d0), 64'd0);
    chk("mrst_no_frame", 64'(obs0.size()), 64'd0);
    run_vec(0, 7'h3C, 1'b1, 64'h0F1E_2D3C_4B5A_6978, 64'h9999_8888_7777_6666,
            64'h9999_8888_7777_6666, 584, "post_rst");

    // Randomized transactions against the frame-level model.
    for (int r = 0; r < 8; r++) begin
      int          i;
      logic [6:0]  a;
      logic        w;
      logic [63:0] d, rv;
      i  = r % 2;
      a  = 7'($urandom_range(0, 127));
      w  = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom} & mask_of(i);
      rv = {$urandom, $urandom} & mask_of(i);
      run_vec(i, a, w, d, rv, rv, busy_len(i), $sformatf("rnd%0d", r));
    end

    chk("sck_high_while_cs_high", 64'(viol[0] + viol[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
